// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Debug readout engine for the A read port of the register file. When started,
// it walks the read address through every register and waits for the read path
// to settle. It then captures each value and hands it out as one beat of a
// valid/ready stream. Hold stays high for the whole scan so that the datapath
// freezes and the snapshot is coherent.
//
// Ports
//   Clk        system clock, all state changes on its rising edge
//   Reset      asynchronous, active-high reset
//   Start      begin a scan (only looked at while idle)
//   Abort      synchronous cancel of a running scan
//   RA         register file A-port read address
//   BusA       register file A-port read data
//   Hold       high while a scan is in progress (stall write-back and PC)
//   DumpData   captured register value
//   DumpIdx    index of the register carried in DumpData
//   DumpValid  DumpData/DumpIdx hold a beat
//   DumpReady  consumer accepts the current beat
//   Done       one-cycle pulse once the last beat has been accepted
module regfile_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_WAIT  = 1    // settle cycles, 1..7
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Abort,
    output logic [ADDR_WIDTH-1:0] RA,
    input  logic [DATA_WIDTH-1:0] BusA,
    output logic                  Hold,
    output logic [DATA_WIDTH-1:0] DumpData,
    output logic [ADDR_WIDTH-1:0] DumpIdx,
    output logic                  DumpValid,
    input  logic                  DumpReady,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IdxOne   = ADDR_WIDTH'(1);
    // The wait counter is loaded with READ_WAIT rather than READ_WAIT-1.
    // RA is a registered copy of idx, so it only reaches the register file one
    // cycle after idx changes. The extra count covers that cycle. After it,
    // BusA still gets the full READ_WAIT settle cycles.
    localparam logic [2:0]            WaitLoad = 3'(READ_WAIT);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   ra_q;
    logic [2:0]              waitCnt_q;
    logic [DATA_WIDTH-1:0]   dumpData_q;
    logic [ADDR_WIDTH-1:0]   dumpIdx_q;
    logic                    dumpValid_q;
    logic                    hold_q;
    logic                    done_q;

    // Scan sequencer. All outputs are registered here.
    // Abort is tested before the handshake in PRESENT, so it has priority.
    // A beat accepted on the same edge still counts for the consumer, but
    // nothing follows it.
    // idx only advances below the last index, so it never wraps.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ra_q        <= '0;
            waitCnt_q   <= '0;
            dumpData_q  <= '0;
            dumpIdx_q   <= '0;
            dumpValid_q <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ra_q   <= idx_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        idx_q     <= '0;
                        hold_q    <= 1'b1;
                        waitCnt_q <= WaitLoad;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (Abort) begin
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (waitCnt_q == 3'd0) begin
                        dumpData_q  <= BusA;
                        dumpIdx_q   <= idx_q;
                        dumpValid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end else begin
                        waitCnt_q <= waitCnt_q - 3'd1;
                    end
                end
                PRESENT: begin
                    if (Abort) begin
                        dumpValid_q <= 1'b0;
                        hold_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (DumpReady) begin
                        dumpValid_q <= 1'b0;
                        if (idx_q == LastIdx) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q     <= idx_q + IdxOne;
                            waitCnt_q <= WaitLoad;
                            state_q   <= WAIT;
                        end
                    end
                end
                DONE: begin
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign RA        = ra_q;
    assign Hold      = hold_q;
    assign DumpData  = dumpData_q;
    assign DumpIdx   = dumpIdx_q;
    assign DumpValid = dumpValid_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//
// Drives regfile_dump_reader against a small combinational register file.
// The expected stream is computed by a cycle-level behavioural model of the
// scan: an active flag, the current beat, and a count of cycles until the beat
// appears. Every cycle, the DUT outputs are compared against that model.
// Literal expectations pin the beat data, latency, spacing and Done timing.
module tb_regfile_dump_reader;

    localparam int NumRegs    = 32;
    localparam int DataWidth  = 64;
    localparam int AddrWidth  = 5;
    localparam int ReadWait   = 3;
    localparam int BeatPeriod = ReadWait + 2;
    localparam int ScanBudget = 2000;

    typedef struct packed {
        logic [AddrWidth-1:0] idx;
        logic [DataWidth-1:0] data;
    } beat_t;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Start;
    logic                 Abort;
    logic [AddrWidth-1:0] RA;
    logic [DataWidth-1:0] BusA;
    logic                 Hold;
    logic [DataWidth-1:0] DumpData;
    logic [AddrWidth-1:0] DumpIdx;
    logic                 DumpValid;
    logic                 DumpReady;
    logic                 Done;

    logic [DataWidth-1:0] regs [NumRegs];

    int nVectors     = 0;
    int nMiscompares = 0;

    // Behavioural model state
    bit                   mActive    = 1'b0;
    bit                   mValid     = 1'b0;
    bit                   mDone      = 1'b0;
    bit                   mRaZero    = 1'b1;
    int                   mBeat      = 0;
    int                   mCount     = 0;
    int                   mIdx       = 0;
    logic [DataWidth-1:0] mData      = '0;
    int                   mDoneCount = 0;
    beat_t                deliv[$];

    // Observations of the DUT
    int    cycle      = 0;
    beat_t obs[$];
    int    riseQ[$];
    int    holdRise   = 0;
    int    doneCycle  = 0;
    int    doneCount  = 0;
    int    idx5Cycles = 0;
    bit    prevValid  = 1'b0;
    bit    prevHold   = 1'b0;
    bit    prevDone   = 1'b0;

    // Per-scan baselines into the ever-growing observation records
    int obsBase, delivBase, riseBase, doneBase, mDoneBase, idx5Base;

    regfile_dump_reader #(
        .NUM_REGS  (NumRegs),
        .DATA_WIDTH(DataWidth),
        .ADDR_WIDTH(AddrWidth),
        .READ_WAIT (ReadWait)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Abort    (Abort),
        .RA       (RA),
        .BusA     (BusA),
        .Hold     (Hold),
        .DumpData (DumpData),
        .DumpIdx  (DumpIdx),
        .DumpValid(DumpValid),
        .DumpReady(DumpReady),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    // Register file read port; the top register reads as zero
    assign BusA = (RA == AddrWidth'(NumRegs - 1)) ? '0 : regs[RA];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the edge that sampled them
    task automatic applyStimulus(input logic s, input logic a, input logic r);
        Start     = s;
        Abort     = a;
        DumpReady = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic markScan();
        obsBase   = obs.size();
        delivBase = deliv.size();
        riseBase  = riseQ.size();
        doneBase  = doneCount;
        mDoneBase = mDoneCount;
        idx5Base  = idx5Cycles;
    endtask

    task automatic checkFullScan(input string tag);
        int n;
        n = obs.size() - obsBase;
        checkOutput({tag, " beatCount"}, 64'(n), 64'(NumRegs));
        for (int i = 0; i < n && i < NumRegs; i++) begin
            checkOutput({tag, " beatIdx"}, 64'(obs[obsBase+i].idx), 64'(i));
            checkOutput({tag, " beatData"}, obs[obsBase+i].data,
                        (i == NumRegs - 1) ? 64'h0 : regs[i]);
        end
        checkOutput({tag, " doneCount"}, 64'(doneCount - doneBase), 64'd1);
        checkOutput({tag, " Hold released"}, 64'(Hold), 64'd0);
    endtask

    // Reference model: what the stream must look like, one update per edge
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mActive = 1'b0;
            mValid  = 1'b0;
            mDone   = 1'b0;
            mRaZero = 1'b1;
            mBeat   = 0;
            mCount  = 0;
            mIdx    = 0;
            mData   = '0;
        end else if (mDone) begin
            mDone   = 1'b0;
            mActive = 1'b0;
        end else if (!mActive) begin
            if (Start) begin
                mActive = 1'b1;
                mRaZero = 1'b0;
                mBeat   = 0;
                mCount  = ReadWait + 1;
            end
        end else begin
            if (mValid && DumpReady)
                deliv.push_back(beat_t'{idx: AddrWidth'(mIdx), data: mData});
            if (Abort) begin
                mActive = 1'b0;
                mValid  = 1'b0;
            end else if (mValid) begin
                if (DumpReady) begin
                    mValid = 1'b0;
                    if (mBeat == NumRegs - 1) begin
                        mDone = 1'b1;
                        mDoneCount++;
                    end else begin
                        mBeat++;
                        mCount = ReadWait + 1;
                    end
                end
            end else begin
                mCount--;
                if (mCount == 0) begin
                    mValid = 1'b1;
                    mIdx   = mBeat;
                    mData  = (mBeat == NumRegs - 1) ? '0 : regs[AddrWidth'(mBeat)];
                end
            end
        end
    end

    always @(posedge Clk) cycle++;

    // Compare the DUT against the model on every cycle, away from the edge
    always @(negedge Clk) begin
        checkOutput("Hold", 64'(Hold), 64'(mActive));
        checkOutput("DumpValid", 64'(DumpValid), 64'(mValid));
        checkOutput("Done", 64'(Done), 64'(mDone));
        if (mValid) begin
            checkOutput("DumpIdx", 64'(DumpIdx), 64'(mIdx));
            checkOutput("DumpData", DumpData, mData);
        end
        if (mRaZero)
            checkOutput("RA after reset", 64'(RA), 64'd0);
        else if (mActive && !mDone && mCount != ReadWait + 1)
            checkOutput("RA", 64'(RA), 64'(mBeat));

        if (DumpValid && !prevValid) riseQ.push_back(cycle);
        if (Hold && !prevHold) holdRise = cycle;
        if (Done && !prevDone) begin
            doneCount++;
            doneCycle = cycle;
        end
        if (DumpValid && DumpIdx == AddrWidth'(5)) idx5Cycles++;
        if (DumpValid && DumpReady) obs.push_back(beat_t'{idx: DumpIdx, data: DumpData});
        prevValid = DumpValid;
        prevHold  = Hold;
        prevDone  = Done;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got t=%0t, limit 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  c;
        int  stall;
        int  n;
        int  m;
        bit  sent;
        bit  s;
        bit  a;
        bit  r;

        Reset     = 1'b0;
        Start     = 1'b0;
        Abort     = 1'b0;
        DumpReady = 1'b0;
        for (int i = 0; i < NumRegs; i++)
            regs[i] = 64'h1111_0000_0000_0000 + 64'(i);

        #1 Reset = 1'b1;
        #2;
        checkOutput("reset RA", 64'(RA), 64'd0);
        checkOutput("reset DumpData", DumpData, 64'd0);
        checkOutput("reset DumpIdx", 64'(DumpIdx), 64'd0);
        checkOutput("reset DumpValid", 64'(DumpValid), 64'd0);
        checkOutput("reset Hold", 64'(Hold), 64'd0);
        checkOutput("reset Done", 64'(Done), 64'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // Full scan with the consumer always ready
        $display("[TB] full scan, DumpReady tied high");
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        c = 0;
        while (mActive && c < ScanBudget) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            c++;
        end
        checkFullScan("scan1");
        if (obs.size() - obsBase > 31) begin
            checkOutput("scan1 beat5 data", obs[obsBase+5].data, 64'h1111_0000_0000_0005);
            checkOutput("scan1 beat30 data", obs[obsBase+30].data, 64'h1111_0000_0000_001e);
            checkOutput("scan1 beat31 data", obs[obsBase+31].data, 64'h0);
        end
        checkOutput("scan1 validRises", 64'(riseQ.size() - riseBase), 64'(NumRegs));
        if (riseQ.size() - riseBase == NumRegs) begin
            checkOutput("scan1 first latency", 64'(riseQ[riseBase] - holdRise), 64'd4);
            for (int i = 1; i < NumRegs; i++)
                checkOutput("scan1 beat spacing", 64'(riseQ[riseBase+i] - riseQ[riseBase+i-1]),
                            64'(BeatPeriod));
            checkOutput("scan1 Done after last beat",
                        64'(doneCycle - riseQ[riseBase+NumRegs-1]), 64'd1);
        end

        // Backpressure: hold beat 5 for ten cycles
        $display("[TB] backpressure on beat 5");
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        stall = 0;
        c = 0;
        while (mActive && c < ScanBudget) begin
            r = 1'b1;
            if (mValid && mBeat == 5 && stall < 10) begin
                r = 1'b0;
                stall++;
            end
            applyStimulus(1'b0, 1'b0, r);
            c++;
        end
        checkFullScan("stall");
        checkOutput("stall beat5 visible cycles", 64'(idx5Cycles - idx5Base), 64'd11);

        // Random data, random readiness, Start re-pulsed at beat 3, Abort during DONE
        $display("[TB] restart ignored mid-scan, Abort ignored in DONE");
        for (int i = 0; i < NumRegs; i++)
            regs[i] = {$urandom, $urandom};
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        sent = 1'b0;
        c = 0;
        while (mActive && c < ScanBudget) begin
            s = mValid && mBeat == 3 && !sent;
            if (s) sent = 1'b1;
            a = mDone;
            r = ($urandom_range(0, 3) != 0);
            applyStimulus(s, a, r);
            c++;
        end
        checkFullScan("restart");

        // Abort on the beat-7 handshake
        $display("[TB] abort on beat 7 handshake");
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        sent = 1'b0;
        c = 0;
        while (mActive && c < ScanBudget) begin
            a = mValid && mBeat == 7 && !sent;
            if (a) sent = 1'b1;
            applyStimulus(1'b0, a, 1'b1);
            c++;
        end
        checkOutput("abort beatCount", 64'(obs.size() - obsBase), 64'd8);
        if (obs.size() > obsBase)
            checkOutput("abort last idx", 64'(obs[obs.size()-1].idx), 64'd7);
        checkOutput("abort doneCount", 64'(doneCount - doneBase), 64'd0);
        checkOutput("abort Hold released", 64'(Hold), 64'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b1);
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        c = 0;
        while (mActive && c < ScanBudget) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            c++;
        end
        checkFullScan("after abort");

        // Asynchronous reset in the middle of the WAIT for beat 12
        $display("[TB] asynchronous reset during beat 12 wait");
        markScan();
        applyStimulus(1'b1, 1'b0, 1'b1);
        c = 0;
        while (!(mActive && !mValid && mBeat == 12 && mCount < ReadWait + 1) && c < ScanBudget) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            c++;
        end
        #2 Reset = 1'b1;
        #1;
        checkOutput("midreset DumpValid", 64'(DumpValid), 64'd0);
        checkOutput("midreset Hold", 64'(Hold), 64'd0);
        checkOutput("midreset RA", 64'(RA), 64'd0);
        checkOutput("midreset DumpIdx", 64'(DumpIdx), 64'd0);
        checkOutput("midreset DumpData", DumpData, 64'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midreset beatCount", 64'(obs.size() - obsBase), 64'd12);

        // Random stress against the model
        $display("[TB] randomized scans");
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NumRegs; i++)
                regs[i] = {$urandom, $urandom};
            markScan();
            applyStimulus(1'b1, 1'b0, 1'b1);
            c = 0;
            while (mActive && c < ScanBudget) begin
                s = ($urandom_range(0, 20) == 0);
                a = ($urandom_range(0, 150) == 0);
                r = ($urandom_range(0, 3) != 0);
                applyStimulus(s, a, r);
                c++;
            end
            for (int i = 0; i < 3; i++)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            n = obs.size() - obsBase;
            m = deliv.size() - delivBase;
            checkOutput("rand beatCount", 64'(n), 64'(m));
            for (int i = 0; i < n && i < m; i++) begin
                checkOutput("rand beatIdx", 64'(obs[obsBase+i].idx), 64'(deliv[delivBase+i].idx));
                checkOutput("rand beatData", obs[obsBase+i].data, deliv[delivBase+i].data);
            end
            checkOutput("rand doneCount", 64'(doneCount - doneBase), 64'(mDoneCount - mDoneBase));
            checkOutput("rand Hold released", 64'(Hold), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
